axi_uart_rx_slave: RTL and testbench



---
 rtl/axi_uart_rx_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_uart_rx_slave.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_uart_rx_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_uart_rx_slave
// Brief    : AXI4-lite UART receiver with a UART-lite compatible register map.
// Revision : 1.0 - initial release
// ============================================================================
module axi_uart_rx_slave #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rxd,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp
);

    localparam int                   c_cnt_w   = $clog2(CLK_PER_BIT);
    localparam int                   c_depth   = 1 << FIFO_ADDR_W;
    localparam logic [c_cnt_w-1:0]   c_half    = c_cnt_w'(CLK_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0]   c_full    = c_cnt_w'(CLK_PER_BIT - 1);
    localparam logic [FIFO_ADDR_W:0] c_depth_v = (FIFO_ADDR_W + 1)'(c_depth);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } rx_state_t;

    rx_state_t              r_state, w_state_nxt;
    logic                   r_rxd_meta, r_rxd_s;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2:0]             r_bit;
    logic [7:0]             r_shift;
    logic                   w_cnt_clr, w_sample, w_push, w_frame_set;

    logic [7:0]             r_mem [c_depth];
    logic [FIFO_ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_ADDR_W:0]   r_count;
    logic                   r_ovr, r_ferr;

    logic                   r_arready, r_rvalid, r_wr_rdy, r_bvalid;
    logic [31:0]            r_rdata, w_rd_data;
    logic                   w_ar_hs, w_rd_fifo, w_rd_stat, w_pop, w_wr_hs, w_flush;
    logic                   w_not_empty, w_fifo_full, w_push_ok, w_ovr_set;
    logic                   w_unused;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_sample    = 1'b0;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        case (r_state)
            S_IDLE: if (!r_rxd_s) begin
                w_state_nxt = S_START;
                w_cnt_clr   = 1'b1;
            end
            S_START: if (r_cnt == c_half) begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = r_rxd_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (r_cnt == c_full) begin
                w_cnt_clr = 1'b1;
                w_sample  = 1'b1;
                if (r_bit == 3'd7) w_state_nxt = S_STOP;
            end
            S_STOP: if (r_cnt == c_full) begin
                w_cnt_clr = 1'b1;
                if (r_rxd_s) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_frame_set = 1'b1;
                    w_state_nxt = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: if (r_rxd_s) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (w_sample) begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= {r_rxd_s, r_shift[7:1]};
            end else if (r_state == S_START) begin
                r_bit <= '0;
            end
        end
    end

    assign w_ar_hs     = axi_arvalid && r_arready;
    assign w_rd_fifo   = w_ar_hs && (axi_araddr[3:2] == 2'b00);
    assign w_rd_stat   = w_ar_hs && (axi_araddr[3:2] == 2'b10);
    assign w_not_empty = (r_count != '0);
    assign w_fifo_full = (r_count == c_depth_v);
    assign w_pop       = w_rd_fifo && w_not_empty;
    assign w_wr_hs     = r_wr_rdy && axi_awvalid && axi_wvalid;
    assign w_flush     = w_wr_hs && (axi_awaddr[3:2] == 2'b11) && axi_wdata[1];
    // A pop in the same cycle frees the slot the push needs; flush discards both.
    assign w_push_ok   = w_push && (!w_fifo_full || w_pop) && !w_flush;
    assign w_ovr_set   = w_push && w_fifo_full && !w_pop && !w_flush;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Error events beat a same-cycle clear so no event is ever lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_ovr_set)                  r_ovr <= 1'b1;
            else if (w_flush || w_rd_stat)  r_ovr <= 1'b0;
            if (w_frame_set)                r_ferr <= 1'b1;
            else if (w_flush || w_rd_stat)  r_ferr <= 1'b0;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (axi_araddr[3:2])
            2'b00:   w_rd_data = {24'h0, w_not_empty ? r_mem[r_rd_ptr] : 8'h00};
            2'b10:   w_rd_data = {25'h0, r_ferr, r_ovr, 2'b00, 1'b1, w_fifo_full, w_not_empty};
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
        end else if (r_rvalid && axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_rdy <= 1'b0;
            r_bvalid <= 1'b0;
        end else begin
            r_wr_rdy <= axi_awvalid && axi_wvalid && !r_bvalid && !r_wr_rdy;
            if (w_wr_hs)         r_bvalid <= 1'b1;
            else if (axi_bready) r_bvalid <= 1'b0;
        end
    end

    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = 2'b00;
    assign axi_awready = r_wr_rdy;
    assign axi_wready  = r_wr_rdy;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = 2'b00;

    assign w_unused = ^{axi_awprot, axi_wstrb, axi_arprot, axi_awaddr[31:4], axi_awaddr[1:0],
                        axi_araddr[31:4], axi_araddr[1:0], axi_wdata[31:2], axi_wdata[0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_uart_rx_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_uart_rx_slave
// Brief    : Directed, table-driven bench for axi_uart_rx_slave (8 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_uart_rx_slave;

    localparam int c_cpb = 8;
    localparam logic [2:0] OP_SEND = 3'd0, OP_BAD = 3'd1, OP_READ = 3'd2,
                           OP_WRITE = 3'd3, OP_GLITCH = 3'd4;

    logic        clk = 1'b0;
    logic        rstn, rxd;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    axi_uart_rx_slave #(.CLK_PER_BIT(c_cpb), .FIFO_ADDR_W(4)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awprot(axi_awprot), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [3:0] a, input logic [7:0] d,
                       input logic [31:0] e);
        vecs.push_back('{op: op, addr: a, data: d, exp: e});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (c_cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (c_cpb) @(negedge clk);
        end
        rxd = stop;
        repeat (c_cpb) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_sig(input string name, input logic which_ar);
        int n = 0;
        while (((which_ar ? axi_arready : axi_awready) !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check(name, 32'h0, 32'h1);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        axi_arvalid = 1'b1;
        axi_araddr  = {28'hABCDE12, a};
        wait_sig("arready_timeout", 1'b1);
        @(negedge clk);
        axi_arvalid = 1'b0;
        while (axi_rvalid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rvalid_timeout", 32'h0, 32'h1);
        d = axi_rdata;
        axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_awaddr  = {28'h0, a};
        axi_wdata   = d;
        wait_sig("awready_timeout", 1'b0);
        @(negedge clk);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b1;
        @(negedge clk);
        axi_bready  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, {31'h0, axi_arready}, 32'h1);
        check({tag, "_awready"}, {31'h0, axi_awready}, 32'h0);
        check({tag, "_wready"},  {31'h0, axi_wready},  32'h0);
        check({tag, "_rvalid"},  {31'h0, axi_rvalid},  32'h0);
        check({tag, "_bvalid"},  {31'h0, axi_bvalid},  32'h0);
        check({tag, "_rdata"},   axi_rdata,            32'h0);
        check({tag, "_resp"},    {28'h0, axi_rresp, axi_bresp}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        rstn = 1'b0; rxd = 1'b1;
        axi_awvalid = 0; axi_wvalid = 0; axi_bready = 0; axi_arvalid = 0; axi_rready = 0;
        axi_awaddr = '0; axi_wdata = '0; axi_araddr = '0;
        axi_awprot = '0; axi_arprot = '0; axi_wstrb = 4'hF;

        // Basic byte, ordering, empty pop, unmapped regs
        add(OP_SEND, 4'h0, 8'hA5, 0);
        add(OP_READ, 4'h8, 0, 32'h05);
        add(OP_READ, 4'h0, 0, 32'hA5);
        add(OP_READ, 4'h8, 0, 32'h04);
        add(OP_SEND, 4'h0, 8'h12, 0);
        add(OP_SEND, 4'h0, 8'h34, 0);
        add(OP_SEND, 4'h0, 8'h56, 0);
        add(OP_READ, 4'h0, 0, 32'h12);
        add(OP_READ, 4'h0, 0, 32'h34);
        add(OP_READ, 4'h0, 0, 32'h56);
        add(OP_READ, 4'h0, 0, 32'h00);
        add(OP_READ, 4'h8, 0, 32'h04);
        add(OP_READ, 4'h4, 0, 32'h00);
        add(OP_READ, 4'hC, 0, 32'h00);
        // Framing error then clear-on-read, glitch rejection
        add(OP_BAD,  4'h0, 8'hFF, 0);
        add(OP_READ, 4'h8, 0, 32'h44);
        add(OP_READ, 4'h8, 0, 32'h04);
        add(OP_READ, 4'h0, 0, 32'h00);
        add(OP_GLITCH, 4'h0, 0, 0);
        add(OP_READ, 4'h8, 0, 32'h04);
        // Writes that must not disturb the FIFO
        add(OP_SEND,  4'h0, 8'h77, 0);
        add(OP_WRITE, 4'h0, 8'hFF, 0);
        add(OP_WRITE, 4'h8, 8'h62, 0);
        add(OP_WRITE, 4'hC, 8'h01, 0);
        add(OP_READ,  4'h8, 0, 32'h05);
        add(OP_READ,  4'h0, 0, 32'h77);
        // Overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) add(OP_SEND, 4'h0, 8'(i), 0);
        add(OP_READ, 4'h8, 0, 32'h27);
        for (int i = 0; i < 16; i++) add(OP_READ, 4'h0, 0, 32'(i));
        add(OP_READ, 4'h8, 0, 32'h04);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_SEND:  send_byte(vecs[i].data, 1'b1);
                OP_BAD:   send_byte(vecs[i].data, 1'b0);
                OP_WRITE: axi_write(vecs[i].addr, {24'h0, vecs[i].data});
                OP_GLITCH: begin
                    rxd = 1'b0;
                    repeat (3) @(negedge clk);
                    rxd = 1'b1;
                    repeat (3 * c_cpb) @(negedge clk);
                end
                default: begin
                    axi_read(vecs[i].addr, rd);
                    check($sformatf("vec%0d_rd%0h", i, vecs[i].addr), rd, vecs[i].exp);
                end
            endcase
        end

        // Flush with bvalid timing and bready back-pressure
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), 1'b1);
        @(negedge clk);
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_awaddr = 32'hC; axi_wdata = 32'h2;
        wait_sig("flush_awready_timeout", 1'b0);
        check("flush_wready_pulse", {31'h0, axi_wready}, 32'h1);
        check("flush_bvalid_in_hs", {31'h0, axi_bvalid}, 32'h0);
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        check("flush_bvalid_after_hs", {31'h0, axi_bvalid}, 32'h1);
        check("flush_awready_dropped", {31'h0, axi_awready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bvalid_hold%0d", i), {31'h0, axi_bvalid}, 32'h1);
        end
        axi_bready = 1'b1;
        @(negedge clk);
        axi_bready = 1'b0;
        check("bvalid_released", {31'h0, axi_bvalid}, 32'h0);
        axi_read(4'h8, rd);
        check("flush_stat", rd, 32'h04);

        // rready back-pressure on an RX_FIFO read
        send_byte(8'h3C, 1'b1);
        @(negedge clk);
        axi_arvalid = 1'b1; axi_araddr = 32'h0;
        wait_sig("hold_arready_timeout", 1'b1);
        @(negedge clk);
        axi_arvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("hold_rdata%0d", i), axi_rdata, 32'h3C);
            check($sformatf("hold_arready%0d", i), {31'h0, axi_arready}, 32'h0);
            check($sformatf("hold_rvalid%0d", i), {31'h0, axi_rvalid}, 32'h1);
            @(negedge clk);
        end
        axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0;
        check("hold_rvalid_done", {31'h0, axi_rvalid}, 32'h0);
        check("hold_arready_back", {31'h0, axi_arready}, 32'h1);

        // Asynchronous reset in the middle of a frame
        rxd = 1'b0;
        repeat (c_cpb) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * c_cpb) @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("midframe");
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (12 * c_cpb) @(negedge clk);
        axi_read(4'h8, rd);
        check("post_reset_stat", rd, 32'h04);
        axi_read(4'h0, rd);
        check("post_reset_pop", rd, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
